// File: rtl/fft_pkg.sv
// Shared state encoding and default constants for the FFT sequencing controller.
package fft_pkg;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_RD_A,
        ST_RD_B,
        ST_RD_TW,
        ST_RD_LAST,
        ST_BB_GO,
        ST_BB_WAIT,
        ST_WR_A,
        ST_WR_B,
        ST_NEXT,
        ST_DONE
    } fft_state_e;

    localparam int DATA_BASE_DEF = 0;

    function automatic int stage_w(input int log2_n);
        return (log2_n > 1) ? $clog2(log2_n) : 1;
    endfunction

    // Twiddle table sits directly above the N-sample data block by default.
    function automatic int tw_base_def(input int log2_n);
        return 1 << log2_n;
    endfunction

endpackage

// File: rtl/fft_addr_gen.sv
// In-place radix-2 DIT operand and twiddle addresses for stage s, butterfly b.
module fft_addr_gen
    import fft_pkg::*;
#(
    parameter int LOG2_N    = 5,
    parameter int ADDR_W    = LOG2_N + 1,
    parameter int DATA_BASE = DATA_BASE_DEF,
    parameter int TW_BASE   = tw_base_def(LOG2_N)
) (
    input  logic [stage_w(LOG2_N)-1:0] s,
    input  logic [LOG2_N-2:0]          b,
    output logic [ADDR_W-1:0]          addr_a,
    output logic [ADDR_W-1:0]          addr_b,
    output logic [ADDR_W-1:0]          addr_tw
);

    localparam int SW = stage_w(LOG2_N);

    logic [ADDR_W-1:0] b_ext;
    logic [ADDR_W-1:0] half;
    logic [ADDR_W-1:0] pos;
    logic [ADDR_W-1:0] grp_off;
    logic [ADDR_W-1:0] k;

    always_comb begin
        b_ext   = ADDR_W'(b);
        half    = ADDR_W'(1) << s;
        pos     = b_ext & (half - ADDR_W'(1));
        // grp*2*half == (b - pos) * 2, avoiding an s+1 shift overflow
        grp_off = (b_ext - pos) << 1;
        k       = pos << (SW'(LOG2_N - 1) - s);
        addr_a  = ADDR_W'(DATA_BASE) + grp_off + pos;
        addr_b  = addr_a + half;
        addr_tw = ADDR_W'(TW_BASE) + k;
    end

endmodule

// File: rtl/fft_seq_ctrl.sv
// FFT butterfly sequencer: walks stages/butterflies, drives SRAM and datapath strobes.
module fft_seq_ctrl
    import fft_pkg::*;
#(
    parameter int LOG2_N    = 5,
    parameter int ADDR_W    = LOG2_N + 1,
    parameter int DATA_BASE = DATA_BASE_DEF,
    parameter int TW_BASE   = tw_base_def(LOG2_N)
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       fft_start,
    input  logic                       fft_inverse,
    input  logic                       abort,
    input  logic                       bb_done,
    output logic [ADDR_W-1:0]          sram_addr,
    output logic                       sram_read_ena,
    output logic                       sram_write_ena,
    output logic                       shift_in_ena,
    output logic                       shift_out_ena,
    output logic                       bb_start,
    output logic                       conj_tw,
    output logic [stage_w(LOG2_N)-1:0] stage,
    output logic [LOG2_N-2:0]          bfly,
    output logic                       busy,
    output logic                       fft_done
);

    localparam int SW = stage_w(LOG2_N);
    localparam int BW = LOG2_N - 1;
    localparam logic [SW-1:0] S_LAST = SW'(LOG2_N - 1);
    localparam logic [BW-1:0] B_LAST = '1;

    fft_state_e        state_q, state_d;
    logic [SW-1:0]     stage_q, stage_d;
    logic [BW-1:0]     bfly_q, bfly_d;
    logic              conj_q, conj_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [ADDR_W-1:0] addr_a, addr_b, addr_tw;

    fft_addr_gen #(
        .LOG2_N   (LOG2_N),
        .ADDR_W   (ADDR_W),
        .DATA_BASE(DATA_BASE),
        .TW_BASE  (TW_BASE)
    ) u_addr_gen (
        .s      (stage_q),
        .b      (bfly_q),
        .addr_a (addr_a),
        .addr_b (addr_b),
        .addr_tw(addr_tw)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            stage_q <= '0;
            bfly_q  <= '0;
            conj_q  <= 1'b0;
            addr_q  <= '0;
        end else begin
            state_q <= state_d;
            stage_q <= stage_d;
            bfly_q  <= bfly_d;
            conj_q  <= conj_d;
            addr_q  <= addr_d;
        end
    end

    always_comb begin
        state_d        = state_q;
        stage_d        = stage_q;
        bfly_d         = bfly_q;
        conj_d         = conj_q;
        addr_d         = addr_q;
        sram_read_ena  = 1'b0;
        sram_write_ena = 1'b0;
        shift_in_ena   = 1'b0;
        shift_out_ena  = 1'b0;
        bb_start       = 1'b0;
        fft_done       = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (fft_start) begin
                    state_d = ST_RD_A;
                    stage_d = '0;
                    bfly_d  = '0;
                    conj_d  = fft_inverse;
                end
            end
            ST_RD_A: begin
                state_d       = ST_RD_B;
                sram_read_ena = 1'b1;
                addr_d        = addr_a;
            end
            ST_RD_B: begin
                state_d       = ST_RD_TW;
                sram_read_ena = 1'b1;
                shift_in_ena  = 1'b1;
                addr_d        = addr_b;
            end
            ST_RD_TW: begin
                state_d       = ST_RD_LAST;
                sram_read_ena = 1'b1;
                shift_in_ena  = 1'b1;
                addr_d        = addr_tw;
            end
            ST_RD_LAST: begin
                state_d      = ST_BB_GO;
                shift_in_ena = 1'b1;
            end
            ST_BB_GO: begin
                state_d  = ST_BB_WAIT;
                bb_start = 1'b1;
            end
            ST_BB_WAIT: begin
                if (bb_done) state_d = ST_WR_A;
            end
            ST_WR_A: begin
                state_d        = ST_WR_B;
                sram_write_ena = 1'b1;
                shift_out_ena  = 1'b1;
                addr_d         = addr_a;
            end
            ST_WR_B: begin
                state_d        = ST_NEXT;
                sram_write_ena = 1'b1;
                shift_out_ena  = 1'b1;
                addr_d         = addr_b;
            end
            ST_NEXT: begin
                if (bfly_q == B_LAST) begin
                    if (stage_q == S_LAST) begin
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_RD_A;
                        bfly_d  = '0;
                        stage_d = stage_q + 1'b1;
                    end
                end else begin
                    state_d = ST_RD_A;
                    bfly_d  = bfly_q + 1'b1;
                end
            end
            ST_DONE: begin
                state_d  = ST_IDLE;
                fft_done = 1'b1;
            end
            default: state_d = ST_IDLE;
        endcase
        // Abort wins over bb_done and the final NEXT->DONE step.
        if (abort && state_q != ST_IDLE) begin
            state_d = ST_IDLE;
            stage_d = stage_q;
            bfly_d  = bfly_q;
        end
    end

    assign sram_addr = addr_d;
    assign conj_tw   = conj_q;
    assign stage     = stage_q;
    assign bfly      = bfly_q;
    assign busy      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_fft_seq_ctrl.sv
// Scoreboard bench for fft_seq_ctrl at LOG2_N=3 with a high-level strobe model.
module tb_fft_seq_ctrl;

    localparam int LOG2_N = 3;
    localparam int N      = 1 << LOG2_N;
    localparam int M      = N / 2;
    localparam int NB     = M * LOG2_N;
    localparam int TWB    = N;
    localparam int AW     = LOG2_N + 1;

    logic              clk = 1'b0;
    logic              rst, fft_start, fft_inverse, abort, bb_done;
    logic [AW-1:0]     sram_addr;
    logic              sram_read_ena, sram_write_ena, shift_in_ena;
    logic              shift_out_ena, bb_start, conj_tw, busy, fft_done;
    logic [1:0]        stage;
    logic [LOG2_N-2:0] bfly;

    typedef struct {
        logic [5:0] sig;
        int         addr;
        int         s;
        int         b;
        logic       conj;
        bit         chk_sb;
        bit         done;
        int         exp_cyc;
        int         t_acc;
    } ev_t;

    ev_t q[$];
    int  total = 0;
    int  bad   = 0;
    int  cyc   = 0;
    bit  in_run = 1'b0;

    fft_seq_ctrl #(
        .LOG2_N   (LOG2_N),
        .ADDR_W   (AW),
        .DATA_BASE(0),
        .TW_BASE  (TWB)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .fft_start     (fft_start),
        .fft_inverse   (fft_inverse),
        .abort         (abort),
        .bb_done       (bb_done),
        .sram_addr     (sram_addr),
        .sram_read_ena (sram_read_ena),
        .sram_write_ena(sram_write_ena),
        .shift_in_ena  (shift_in_ena),
        .shift_out_ena (shift_out_ena),
        .bb_start      (bb_start),
        .conj_tw       (conj_tw),
        .stage         (stage),
        .bfly          (bfly),
        .busy          (busy),
        .fft_done      (fft_done)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] got,
                         input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d", name, got, exp);
        end
    endtask

    task automatic chk_reset(input string tag);
        check({tag, "_flags"}, {busy, fft_done, sram_read_ena, sram_write_ena,
              shift_in_ena, shift_out_ena, bb_start, conj_tw}, 0);
        check({tag, "_stage"}, stage, 0);
        check({tag, "_bfly"}, bfly, 0);
        check({tag, "_addr"}, sram_addr, 0);
    endtask

    task automatic push(input logic [5:0] sig, input int addr, input int s,
                        input int b, input logic inv);
        q.push_back('{sig: sig, addr: addr, s: s, b: b, conj: inv, chk_sb: 1'b1,
                      done: 1'b0, exp_cyc: 0, t_acc: 0});
    endtask

    // Reference: one 7-strobe pattern per butterfly, then a done pulse.
    task automatic build(input bit inv, input int stall_b, input int abort_at,
                         input int t_acc);
        int half, pos, a, bb, tw, extra;
        bb = 0;
        for (int s = 0; s < LOG2_N; s++) begin
            for (int b = 0; b < M; b++) begin
                half = 1 << s;
                pos  = b % half;
                a    = (b / half) * 2 * half + pos;
                bb   = a + half;
                tw   = TWB + pos * (N / (2 * half));
                push(6'b100000, a,  s, b, inv);
                push(6'b101000, bb, s, b, inv);
                push(6'b101000, tw, s, b, inv);
                push(6'b001000, tw, s, b, inv);
                push(6'b000010, tw, s, b, inv);
                push(6'b010100, a,  s, b, inv);
                push(6'b010100, bb, s, b, inv);
            end
        end
        extra = (stall_b >= 0) ? 19 : 0;
        q.push_back('{sig: 6'b000001, addr: bb, s: 0, b: 0, conj: inv,
                      chk_sb: 1'b0, done: 1'b1,
                      exp_cyc: t_acc + 9 * NB + extra, t_acc: t_acc});
        if (abort_at >= 0)
            while (q.size() > abort_at + 1) void'(q.pop_back());
    endtask

    always @(negedge clk) begin : monitor
        logic [5:0] sig;
        ev_t        e;
        sig = {sram_read_ena, sram_write_ena, shift_in_ena, shift_out_ena,
               bb_start, fft_done};
        if (rst === 1'b0) begin
            if (in_run) check("busy_run", busy, 1);
            if (sig != 6'd0) begin
                if (q.size() == 0) begin
                    check("unexp_strobe", sig, 0);
                end else begin
                    e = q.pop_front();
                    check("strobes", sig, e.sig);
                    check("addr", sram_addr, e.addr);
                    check("conj", conj_tw, e.conj);
                    if (e.chk_sb) begin
                        check("stage", stage, e.s);
                        check("bfly", bfly, e.b);
                    end
                    if (e.done)
                        check("done_lat", cyc - e.t_acc + 1,
                              e.exp_cyc - e.t_acc + 1);
                end
            end
        end
    end

    task automatic run_xform(input bit inv, input int stall_b, input int abort_at,
                             input bit abort_start, input int tog,
                             input bit rst_mid);
        int         ev = 0;
        int         stall_left = 0;
        int         nbf = 0;
        bit         fin = 1'b0;
        logic [5:0] sig;
        @(negedge clk); #1;
        bb_done = 1'b1;
        build(inv, stall_b, abort_at, cyc + 1);
        fft_inverse = inv;
        fft_start   = 1'b1;
        abort       = abort_start;
        @(posedge clk); #1;
        fft_start = 1'b0;
        abort     = 1'b0;
        in_run    = 1'b1;
        for (int t = 0; t < 1000 && !fin; t++) begin
            @(negedge clk); #1;
            fft_start = 1'b0;
            if (abort) begin
                abort = 1'b0;
                check("abort_idle", busy, 0);
            end
            if (stall_left > 0) begin
                stall_left--;
                if (stall_left == 0) bb_done = 1'b1;
            end
            if (bb_start) begin
                if (nbf == stall_b) begin
                    bb_done    = 1'b0;
                    stall_left = 20;
                end
                nbf++;
            end
            sig = {sram_read_ena, sram_write_ena, shift_in_ena, shift_out_ena,
                   bb_start, fft_done};
            if (sig != 6'd0) begin
                if (ev == abort_at) begin
                    abort  = 1'b1;
                    in_run = 1'b0;
                end else if (ev == tog) begin
                    fft_inverse = ~fft_inverse;
                    fft_start   = 1'b1;
                end
                ev++;
            end
            if (rst_mid && stall_left == 10) begin
                rst    = 1'b1;
                in_run = 1'b0;
                #1;
                chk_reset("rst_mid");
                q.delete();
                fin = 1'b1;
            end
            if (q.size() == 0 && !abort) fin = 1'b1;
        end
        in_run = 1'b0;
        if (!fin) begin
            check("timeout_left", q.size(), 0);
            q.delete();
            abort = 1'b1;
            @(negedge clk); #1;
            abort = 1'b0;
        end
        if (rst_mid) begin
            repeat (2) @(negedge clk);
            rst = 1'b0;
        end
        bb_done = 1'b1;
        @(negedge clk); #1;
        check("idle_end", busy, 0);
    endtask

    initial begin
        bit inv_r;
        int sb, ab, tg;
        rst         = 1'b1;
        fft_start   = 1'b0;
        fft_inverse = 1'b0;
        abort       = 1'b0;
        bb_done     = 1'b1;
        #2;
        chk_reset("rst_async");
        repeat (2) @(negedge clk);
        chk_reset("rst_hold");
        #1 rst = 1'b0;
        @(negedge clk); #1;
        abort = 1'b1;
        @(negedge clk); #1;
        check("abort_in_idle", busy, 0);
        abort = 1'b0;

        run_xform(1'b0, -1, -1, 1'b0, -1, 1'b0);
        run_xform(1'b1, 5, -1, 1'b0, 12, 1'b0);
        run_xform(1'b0, -1, 33, 1'b0, -1, 1'b0);
        run_xform(1'b0, -1, -1, 1'b1, 40, 1'b0);

        for (int i = 0; i < 6; i++) begin
            inv_r = 1'($urandom_range(0, 1));
            sb = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, NB - 1)) : -1;
            ab = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, 7 * NB - 1)) : -1;
            tg = int'($urandom_range(0, 60));
            if (ab >= 0 && tg + 2 >= ab) tg = -1;
            run_xform(inv_r, sb, ab, 1'($urandom_range(0, 1)), tg, 1'b0);
        end

        run_xform(1'b1, 6, -1, 1'b0, -1, 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
